// File: rtl/sqrt_chk_pkg.sv
// Shared types and widths for the square-root sweep checker and its squarer.
package sqrt_chk_pkg;
  localparam int W     = 14;
  localparam int SQ_W  = 9;
  localparam int RES_W = 17;
  localparam int ERR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_SAMPLE, S_SQ_LO, S_SQ_HI, S_CHECK, S_NEXT, S_DONE
  } state_t;

  function automatic logic [RES_W-1:0] zext(input logic [W-1:0] v);
    return {{(RES_W-W){1'b0}}, v};
  endfunction
endpackage

// File: rtl/sqrt_sweep_checker_if.sv
// Link between the sweep checker (master) and the square-root block under test (slave).
interface sqrt_sweep_checker_if;
  logic [sqrt_chk_pkg::W-1:0] dut_in;
  logic                       dut_rst_n;
  logic [sqrt_chk_pkg::W-1:0] dut_sqrt;

  modport master (output dut_in, output dut_rst_n, input dut_sqrt);
  modport slave  (input dut_in, input dut_rst_n, output dut_sqrt);
endinterface

// File: rtl/seq_squarer.sv
// Shift-add squarer: one multiplier bit per cycle, done pulses 10 cycles after start.
module seq_squarer
  import sqrt_chk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SQ_W-1:0]  a,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] p
);
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RES_W-1:0] p_q, p_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] mcand_q, mcand_d;
  logic [SQ_W-1:0]  mplier_q, mplier_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [RES_W-1:0] sum;

  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    p_d      = p_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sum      = mplier_q[0] ? acc_q + mcand_q : acc_q;
    if (!busy_q) begin
      if (start) begin
        busy_d   = 1'b1;
        acc_d    = '0;
        mcand_d  = {{(RES_W-SQ_W){1'b0}}, a};
        mplier_d = a;
        cnt_d    = '0;
      end
    end else begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 4'd1;
      // Last of the SQ_W partial products: publish and free up for the next start.
      if (cnt_q == 4'(SQ_W-1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        p_d    = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      p_q      <= p_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
endmodule

// File: rtl/sqrt_sweep_checker.sv
// Sweeps the square-root block over START..STOP and checks r*r <= in < (r+1)*(r+1).
module sqrt_sweep_checker
  import sqrt_chk_pkg::*;
#(
  parameter int SETTLE = 32,
  parameter int START  = 0,
  parameter int STOP   = 16383
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  sqrt_sweep_checker_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [W-1:0]         first_err_in,
  output logic [W-1:0]         first_err_sqrt
);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     cur_q, cur_d;
  logic [15:0]      settle_q, settle_d;
  logic [W-1:0]     r_q, r_d;
  logic [RES_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             force_q, force_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [W-1:0]     fin_q, fin_d, fsq_q, fsq_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d, rstn_q, rstn_d;
  logic             sq_start, sq_busy, sq_done, ok;
  logic [SQ_W-1:0]  sq_a;
  logic [RES_W-1:0] sq_p;

  seq_squarer u_sq (
    .clk(clk), .rst(rst), .start(sq_start), .a(sq_a),
    .busy(sq_busy), .done(sq_done), .p(sq_p)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    settle_d = settle_q;
    r_d      = r_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    force_d  = force_q;
    err_d    = err_q;
    fin_d    = fin_q;
    fsq_d    = fsq_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    rstn_d   = 1'b1;
    sq_start = 1'b0;
    sq_a     = '0;
    ok       = !force_q && (lo_q <= zext(cur_q)) && (zext(cur_q) < hi_q);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_DRIVE;
          cur_d    = W'(START);
          settle_d = '0;
          err_d    = '0;
          fin_d    = '0;
          fsq_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          rstn_d   = 1'b0;
        end
      end
      S_DRIVE: begin
        settle_d = settle_q + 16'd1;
        if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        r_d = bus.dut_sqrt;
        // A root needing more than 8 bits can never square to a W-bit input.
        if (|bus.dut_sqrt[W-1:8]) begin
          force_d = 1'b1;
          state_d = S_CHECK;
        end else begin
          force_d  = 1'b0;
          sq_start = !sq_busy;
          sq_a     = {1'b0, bus.dut_sqrt[7:0]};
          state_d  = S_SQ_LO;
        end
      end
      S_SQ_LO: begin
        if (sq_done) begin
          lo_d     = sq_p;
          sq_start = 1'b1;
          sq_a     = {1'b0, r_q[7:0]} + 9'd1;
          state_d  = S_SQ_HI;
        end
      end
      S_SQ_HI: begin
        if (sq_done) begin
          hi_d    = sq_p;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!ok) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          if (err_q == '0) begin
            fin_d = cur_q;
            fsq_d = r_q;
          end
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        // Test for STOP before incrementing so STOP = 2^W-1 cannot wrap.
        if (cur_q == W'(STOP)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0);
        end else begin
          cur_d    = cur_q + W'(1);
          settle_d = '0;
          rstn_d   = 1'b0;
          state_d  = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      settle_q <= '0;
      r_q      <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      force_q  <= 1'b0;
      err_q    <= '0;
      fin_q    <= '0;
      fsq_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      rstn_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      settle_q <= settle_d;
      r_q      <= r_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      force_q  <= force_d;
      err_q    <= err_d;
      fin_q    <= fin_d;
      fsq_q    <= fsq_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      rstn_q   <= rstn_d;
    end
  end

  assign bus.dut_in      = cur_q;
  assign bus.dut_rst_n   = rstn_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_in    = fin_q;
  assign first_err_sqrt  = fsq_q;
endmodule

// File: tb/tb_sqrt_sweep_checker.sv
// Directed bench: three checker instances over small ranges driven by a floor-sqrt model.
module tb_sqrt_sweep_checker;
  localparam int S = 2;
  localparam int VC = S + 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        start_v [3];
  int          mode_v  [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        pass_v  [3];
  logic [15:0] err_v   [3];
  logic [13:0] fin_v   [3];
  logic [13:0] fsq_v   [3];
  logic [13:0] din_v   [3];
  logic        rstn_v  [3];

  // mode 0 ideal, 1 wrong at 50, 2 oversized root at 3, 3 always zero
  function automatic logic [13:0] model(input logic [13:0] x, input int mode);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    if (mode == 3) return 14'd0;
    if (mode == 1 && x == 14'd50) return 14'd8;
    if (mode == 2 && x == 14'd3) return 14'h2000;
    return 14'(r);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    sqrt_sweep_checker_if bus ();
    assign bus.dut_sqrt = model(bus.dut_in, mode_v[gi]);
    assign din_v[gi]    = bus.dut_in;
    assign rstn_v[gi]   = bus.dut_rst_n;
    sqrt_sweep_checker #(
      .SETTLE(S),
      .START (gi == 2 ? 16380 : 0),
      .STOP  (gi == 0 ? 63 : (gi == 1 ? 9 : 16383))
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_v[gi]), .bus(bus.master),
      .busy(busy_v[gi]), .done(done_v[gi]), .pass(pass_v[gi]),
      .err_cnt(err_v[gi]), .first_err_in(fin_v[gi]), .first_err_sqrt(fsq_v[gi])
    );
  end

  logic        sq_start = 1'b0;
  logic [8:0]  sq_a = '0;
  logic        sq_busy, sq_done;
  logic [16:0] sq_p;
  seq_squarer u_sq (
    .clk(clk), .rst(rst), .start(sq_start), .a(sq_a),
    .busy(sq_busy), .done(sq_done), .p(sq_p)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic run(input int inst, input int hold, output int cyc, output int lows,
                     output bit fin);
    cyc = 0; lows = 0; fin = 1'b0;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    if (hold == 0) start_v[inst] = 1'b0;
    if (!rstn_v[inst]) lows++;
    while (cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc >= hold) start_v[inst] = 1'b0;
      if (done_v[inst]) begin
        fin = 1'b1;
        break;
      end
      if (!rstn_v[inst]) lows++;
    end
    start_v[inst] = 1'b0;
  endtask

  task automatic chk_reset(input int i, input string tag);
    chk($sformatf("%s_busy", tag), int'(busy_v[i]), 0);
    chk($sformatf("%s_done", tag), int'(done_v[i]), 0);
    chk($sformatf("%s_pass", tag), int'(pass_v[i]), 0);
    chk($sformatf("%s_err", tag), int'(err_v[i]), 0);
    chk($sformatf("%s_fin", tag), int'(fin_v[i]), 0);
    chk($sformatf("%s_fsq", tag), int'(fsq_v[i]), 0);
    chk($sformatf("%s_din", tag), int'(din_v[i]), 0);
    chk($sformatf("%s_rstn", tag), int'(rstn_v[i]), 1);
  endtask

  typedef struct {
    int inst; int mode; int err; int fin; int fsq; int pass; int cyc; int lows;
  } vec_t;

  vec_t tbl [6];
  int   sq_in  [4] = '{0, 11, 255, 256};
  int   sq_exp [4] = '{0, 121, 65025, 65536};

  initial begin
    int cyc, lows, n;
    bit fin;
    tbl[0] = '{0, 0, 0,  0,  0,      1, 64 * VC,         64};
    tbl[1] = '{0, 1, 1,  50, 8,      0, 64 * VC,         64};
    tbl[2] = '{1, 2, 1,  3,  'h2000, 0, 9 * VC + S + 3,  10};
    tbl[3] = '{1, 3, 9,  1,  0,      0, 10 * VC,         10};
    tbl[4] = '{2, 0, 0,  0,  0,      1, 4 * VC,          4};
    tbl[5] = '{1, 0, 0,  0,  0,      1, 10 * VC,         10};
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_reset(i, $sformatf("rst%0d", i));
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      sq_a = 9'(sq_in[k]);
      sq_start = 1'b1;
      @(posedge clk); #1;
      sq_start = 1'b0;
      n = 1;
      while (!sq_done && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("sq%0d_lat", sq_in[k]), n, 10);
      chk($sformatf("sq%0d_p", sq_in[k]), int'(sq_p), sq_exp[k]);
      @(posedge clk); #1;
      chk($sformatf("sq%0d_pulse", sq_in[k]), int'(sq_done), 0);
    end

    for (int t = 0; t < 6; t++) begin
      mode_v[tbl[t].inst] = tbl[t].mode;
      run(tbl[t].inst, 0, cyc, lows, fin);
      chk($sformatf("v%0d_done", t), int'(fin), 1);
      chk($sformatf("v%0d_busy", t), int'(busy_v[tbl[t].inst]), 0);
      chk($sformatf("v%0d_pass", t), int'(pass_v[tbl[t].inst]), tbl[t].pass);
      chk($sformatf("v%0d_err", t), int'(err_v[tbl[t].inst]), tbl[t].err);
      chk($sformatf("v%0d_fin", t), int'(fin_v[tbl[t].inst]), tbl[t].fin);
      chk($sformatf("v%0d_fsq", t), int'(fsq_v[tbl[t].inst]), tbl[t].fsq);
      chk($sformatf("v%0d_cyc", t), cyc, tbl[t].cyc);
      chk($sformatf("v%0d_lows", t), lows, tbl[t].lows);
    end

    // Abort a failing sweep at vector 20 with rst, then restart with start held high.
    mode_v[0] = 3;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 0;
    while (din_v[0] != 14'd20 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reach20", int'(din_v[0]), 20);
    chk("mid_err_before", int'(err_v[0]), 19);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset(0, "mid");
    mode_v[0] = 0;
    run(0, 80, cyc, lows, fin);
    chk("hold_done", int'(fin), 1);
    chk("hold_pass", int'(pass_v[0]), 1);
    chk("hold_err", int'(err_v[0]), 0);
    chk("hold_cyc", cyc, 64 * VC);
    chk("hold_lows", lows, 64);
    chk("hold_din", int'(din_v[0]), 63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
